// File: rtl/data_ram_responder_if.sv
// Data-side request/response bundle between the MEM-stage requester (master)
// and the data RAM responder (slave).
//   da_ren    requester -> responder  read request pulse, any nonzero = full word
//   da_addr   requester -> responder  byte address
//   da_wen    requester -> responder  write byte-enable pulse, bit i = lane i
//   da_wdata  requester -> responder  lane-aligned write data
//   da_rdata  responder -> requester  read word, valid while da_rvalid
//   da_rvalid responder -> requester  one-cycle read response
//   da_wdone  responder -> requester  one-cycle write commit
interface data_ram_responder_if;
  logic [3:0]  da_ren;
  logic [31:0] da_addr;
  logic [3:0]  da_wen;
  logic [31:0] da_wdata;
  logic [31:0] da_rdata;
  logic        da_rvalid;
  logic        da_wdone;

  modport master (
    output da_ren, da_addr, da_wen, da_wdata,
    input  da_rdata, da_rvalid, da_wdone
  );

  modport slave (
    input  da_ren, da_addr, da_wen, da_wdata,
    output da_rdata, da_rvalid, da_wdone
  );
endinterface

// File: rtl/data_ram_responder.sv
// Data RAM responder: word-organised synchronous RAM with byte-lane writes,
// answering one request at a time after a fixed latency of LATENCY cycles.
// Ports:
//   clk        system clock, posedge
//   rst        synchronous reset, active-high
//   bus        data_ram_responder_if slave modport (da_* request/response)
//   busy       registered, 1 while a request is outstanding
//   proto_err  sticky flag for dropped or conflicting requests, cleared by rst
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding, new request accepted this cycle
// RD_WAIT | read accepted, counting down to the response edge
// WR_WAIT | write accepted, counting down to the commit edge
module data_ram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_ram_responder_if.slave  bus,
  output logic                 busy,
  output logic                 proto_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;

  // The response is registered at the edge that ends the last wait cycle, so
  // the wait states last LATENCY-1 cycles and the down-counter starts at
  // LATENCY-2. With LATENCY=1 there is no wait state: IDLE answers directly.
  localparam bit         DIRECT   = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [31:0]       ram [2**ADDR_W];

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        wen_q;
  logic [31:0]       wdata_q;

  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] idx_in;
  logic              unused_addr_bits;

  logic              do_rd;
  logic              do_wr;
  logic [ADDR_W-1:0] acc_idx;
  logic [3:0]        acc_lanes;
  logic [31:0]       acc_data;

  assign req_rd = |bus.da_ren;
  assign req_wr = |bus.da_wen;
  // Upper address bits are dropped so out-of-range addresses wrap.
  assign idx_in = bus.da_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.da_addr[31:ADDR_W+2], bus.da_addr[1:0]};

  // RAM access for this edge: either the pending request reaching its
  // terminal count, or (LATENCY=1) the request arriving in IDLE.
  always_comb begin
    do_rd     = 1'b0;
    do_wr     = 1'b0;
    acc_idx   = idx;
    acc_lanes = wen_q;
    acc_data  = wdata_q;
    case (state)
      IDLE: begin
        if (DIRECT) begin
          acc_idx   = idx_in;
          acc_lanes = bus.da_wen;
          acc_data  = bus.da_wdata;
          if (req_wr) begin
            do_wr = 1'b1;
          end else if (req_rd) begin
            do_rd = 1'b1;
          end
        end
      end
      RD_WAIT: do_rd = (cnt == 4'd0);
      WR_WAIT: do_wr = (cnt == 4'd0);
      default: ;
    endcase
  end

  // RAM contents are deliberately not reset; a write abandoned by reset
  // must not land.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_lanes[i]) begin
          ram[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      idx           <= '0;
      wen_q         <= 4'd0;
      wdata_q       <= 32'd0;
      busy          <= 1'b0;
      proto_err     <= 1'b0;
      bus.da_rdata  <= 32'd0;
      bus.da_rvalid <= 1'b0;
      bus.da_wdone  <= 1'b0;
    end else begin
      bus.da_rvalid <= do_rd;
      bus.da_wdone  <= do_wr;
      if (do_rd) begin
        bus.da_rdata <= ram[acc_idx];
      end

      case (state)
        IDLE: begin
          if (req_wr) begin
            // Write wins a simultaneous read; the read is dropped and flagged.
            if (req_rd) begin
              proto_err <= 1'b1;
            end
            idx     <= idx_in;
            wen_q   <= bus.da_wen;
            wdata_q <= bus.da_wdata;
            if (!DIRECT) begin
              state <= WR_WAIT;
              cnt   <= CNT_LOAD;
              busy  <= 1'b1;
            end
          end else if (req_rd) begin
            idx <= idx_in;
            if (!DIRECT) begin
              state <= RD_WAIT;
              cnt   <= CNT_LOAD;
              busy  <= 1'b1;
            end
          end
        end

        RD_WAIT, WR_WAIT: begin
          if (req_rd || req_wr) begin
            proto_err <= 1'b1;
          end
          if (cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Four responders with LATENCY = 1..4 side by side; instance k has latency k+1.
// Expected behaviour comes from a transaction-level model that tracks the
// cycle number at which each accepted request must answer.
module tb_data_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst   [4];
  logic [3:0]  t_ren   [4];
  logic [3:0]  t_wen   [4];
  logic [31:0] t_addr  [4];
  logic [31:0] t_wdata [4];

  logic [31:0] o_rdata  [4];
  logic        o_rvalid [4];
  logic        o_wdone  [4];
  logic        o_busy   [4];
  logic        o_perr   [4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      data_ram_responder_if bus ();
      assign bus.da_ren   = t_ren[g];
      assign bus.da_wen   = t_wen[g];
      assign bus.da_addr  = t_addr[g];
      assign bus.da_wdata = t_wdata[g];
      assign o_rdata[g]   = bus.da_rdata;
      assign o_rvalid[g]  = bus.da_rvalid;
      assign o_wdone[g]   = bus.da_wdone;
      data_ram_responder #(.ADDR_W(10), .LATENCY(g + 1)) dut (
        .clk       (clk),
        .rst       (t_rst[g]),
        .bus       (bus.slave),
        .busy      (o_busy[g]),
        .proto_err (o_perr[g])
      );
    end
  endgenerate

  // ---------------- reference model ----------------
  int          cyc;
  int          m_resp [4];   // cycle in which the outstanding request answers
  bit          m_wr   [4];
  int          m_idx  [4];
  logic [3:0]  m_wen  [4];
  logic [31:0] m_wd   [4];
  logic [31:0] mem    [4][1024];
  logic        m_rvalid [4];
  logic        m_wdone  [4];
  logic        m_busy   [4];
  logic        m_perr   [4];
  logic [31:0] m_rdata  [4];

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Applies the inputs present in cycle c and yields expected outputs of c+1.
  task automatic model_edge(input int k, input int c);
    int lat;
    bit outstanding;
    lat = k + 1;
    if (t_rst[k]) begin
      m_resp[k]   = -1;
      m_perr[k]   = 1'b0;
      m_rvalid[k] = 1'b0;
      m_wdone[k]  = 1'b0;
      m_busy[k]   = 1'b0;
      m_rdata[k]  = 32'd0;
    end else begin
      outstanding = (m_resp[k] > c);
      if (t_ren[k] != 4'd0 || t_wen[k] != 4'd0) begin
        if (outstanding) begin
          m_perr[k] = 1'b1;
        end else begin
          if (t_ren[k] != 4'd0 && t_wen[k] != 4'd0) m_perr[k] = 1'b1;
          m_resp[k] = c + lat;
          m_wr[k]   = (t_wen[k] != 4'd0);
          m_idx[k]  = int'(t_addr[k][11:2]);
          m_wen[k]  = t_wen[k];
          m_wd[k]   = t_wdata[k];
        end
      end
      m_rvalid[k] = 1'b0;
      m_wdone[k]  = 1'b0;
      if (m_resp[k] == c + 1) begin
        if (m_wr[k]) begin
          for (int i = 0; i < 4; i++)
            if (m_wen[k][i]) mem[k][m_idx[k]][8*i +: 8] = m_wd[k][8*i +: 8];
          m_wdone[k] = 1'b1;
        end else begin
          m_rdata[k]  = mem[k][m_idx[k]];
          m_rvalid[k] = 1'b1;
        end
      end
      m_busy[k] = (m_resp[k] > c + 1);
    end
  endtask

  // Drive one cycle on instance k (all others idle), advance to the next
  // cycle's negedge where outputs are sampled.
  task automatic tick(input int k, input logic [3:0] ren, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wd, input logic r);
    for (int j = 0; j < 4; j++) begin
      t_rst[j] = 1'b0; t_ren[j] = 4'd0; t_wen[j] = 4'd0;
      t_addr[j] = 32'd0; t_wdata[j] = 32'd0;
    end
    t_rst[k] = r; t_ren[k] = ren; t_wen[k] = wen; t_addr[k] = addr; t_wdata[k] = wd;
    @(posedge clk);
    for (int j = 0; j < 4; j++) model_edge(j, cyc);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) tick(k, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Leaves the bench in the wdone / rvalid cycle of the request.
  task automatic do_write(input int k, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wd);
    tick(k, 4'd0, wen, addr, wd, 1'b0);
    idle(k, k);
  endtask

  task automatic do_read(input int k, input logic [31:0] addr);
    tick(k, 4'hF, 4'd0, addr, 32'd0, 1'b0);
    idle(k, k);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      for (int j = 0; j < 4; j++) begin
        t_rst[j] = 1'b1; t_ren[j] = 4'hF; t_wen[j] = 4'd0;
        t_addr[j] = 32'd0; t_wdata[j] = 32'd0;
      end
      @(posedge clk);
      for (int j = 0; j < 4; j++) model_edge(j, cyc);
      cyc++;
      @(negedge clk);
    end
    for (int j = 0; j < 4; j++) begin
      cmp_cnt++; if (o_rvalid[j] !== 1'b0) begin err_cnt++; $display("FAIL reset_rvalid k=%0d got=%b want=0", j, o_rvalid[j]); end
      cmp_cnt++; if (o_wdone[j] !== 1'b0) begin err_cnt++; $display("FAIL reset_wdone k=%0d got=%b want=0", j, o_wdone[j]); end
      cmp_cnt++; if (o_busy[j] !== 1'b0) begin err_cnt++; $display("FAIL reset_busy k=%0d got=%b want=0", j, o_busy[j]); end
      cmp_cnt++; if (o_perr[j] !== 1'b0) begin err_cnt++; $display("FAIL reset_perr k=%0d got=%b want=0", j, o_perr[j]); end
      cmp_cnt++; if (o_rdata[j] !== 32'd0) begin err_cnt++; $display("FAIL reset_rdata k=%0d got=%h want=0", j, o_rdata[j]); end
    end
    idle(0, 1);
  endtask

  task automatic test_latency();
    idle(1, 2);
    tick(1, 4'd0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    cmp_cnt++; if (o_wdone[1] !== 1'b0) begin err_cnt++; $display("FAIL lat_wdone_early got=%b want=0", o_wdone[1]); end
    cmp_cnt++; if (o_busy[1] !== 1'b1) begin err_cnt++; $display("FAIL lat_busy_wait got=%b want=1", o_busy[1]); end
    idle(1, 1);
    cmp_cnt++; if (o_wdone[1] !== 1'b1) begin err_cnt++; $display("FAIL lat_wdone got=%b want=1", o_wdone[1]); end
    cmp_cnt++; if (o_busy[1] !== 1'b0) begin err_cnt++; $display("FAIL lat_busy_resp got=%b want=0", o_busy[1]); end
    tick(1, 4'hF, 4'd0, 32'h10, 32'd0, 1'b0);
    cmp_cnt++; if (o_wdone[1] !== 1'b0) begin err_cnt++; $display("FAIL lat_wdone_width got=%b want=0", o_wdone[1]); end
    cmp_cnt++; if (o_rvalid[1] !== 1'b0) begin err_cnt++; $display("FAIL lat_rvalid_early got=%b want=0", o_rvalid[1]); end
    idle(1, 1);
    cmp_cnt++; if (o_rvalid[1] !== 1'b1) begin err_cnt++; $display("FAIL lat_rvalid got=%b want=1", o_rvalid[1]); end
    cmp_cnt++; if (o_rdata[1] !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL lat_rdata got=%h want=deadbeef", o_rdata[1]); end
    idle(1, 1);
    cmp_cnt++; if (o_rvalid[1] !== 1'b0) begin err_cnt++; $display("FAIL lat_rvalid_width got=%b want=0", o_rvalid[1]); end
    cmp_cnt++; if (o_rdata[1] !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL lat_rdata_hold got=%h want=deadbeef", o_rdata[1]); end
  endtask

  task automatic test_byte_lanes();
    do_write(1, 4'hF, 32'h20, 32'h11223344);
    do_write(1, 4'b0100, 32'h20, 32'h00AA0000);
    do_read(1, 32'h20);
    cmp_cnt++; if (o_rvalid[1] !== 1'b1) begin err_cnt++; $display("FAIL lanes_rvalid1 got=%b want=1", o_rvalid[1]); end
    cmp_cnt++; if (o_rdata[1] !== 32'h11AA3344) begin err_cnt++; $display("FAIL lanes_byte2 got=%h want=11aa3344", o_rdata[1]); end
    do_write(1, 4'b1100, 32'h20, 32'h55660000);
    do_read(1, 32'h20);
    cmp_cnt++; if (o_rdata[1] !== 32'h55663344) begin err_cnt++; $display("FAIL lanes_half got=%h want=55663344", o_rdata[1]); end
    cmp_cnt++; if (o_rdata[1] !== m_rdata[1]) begin err_cnt++; $display("FAIL lanes_model got=%h want=%h", o_rdata[1], m_rdata[1]); end
  endtask

  task automatic test_busy_drop();
    do_write(2, 4'hF, 32'h40, 32'hCAFEF00D);
    idle(2, 1);
    tick(2, 4'hF, 4'd0, 32'h40, 32'd0, 1'b0);
    cmp_cnt++; if (o_perr[2] !== 1'b0) begin err_cnt++; $display("FAIL drop_perr_before got=%b want=0", o_perr[2]); end
    tick(2, 4'd0, 4'hF, 32'h40, 32'hFFFFFFFF, 1'b0);
    cmp_cnt++; if (o_perr[2] !== 1'b1) begin err_cnt++; $display("FAIL drop_perr got=%b want=1", o_perr[2]); end
    cmp_cnt++; if (o_busy[2] !== 1'b1) begin err_cnt++; $display("FAIL drop_busy got=%b want=1", o_busy[2]); end
    idle(2, 1);
    cmp_cnt++; if (o_rvalid[2] !== 1'b1) begin err_cnt++; $display("FAIL drop_rvalid got=%b want=1", o_rvalid[2]); end
    cmp_cnt++; if (o_rdata[2] !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL drop_rdata got=%h want=cafef00d", o_rdata[2]); end
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++; if (o_wdone[2] !== 1'b0) begin err_cnt++; $display("FAIL drop_no_wdone i=%0d got=%b want=0", i, o_wdone[2]); end
      idle(2, 1);
    end
    do_read(2, 32'h40);
    cmp_cnt++; if (o_rdata[2] !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL drop_ram_kept got=%h want=cafef00d", o_rdata[2]); end
    cmp_cnt++; if (o_perr[2] !== 1'b1) begin err_cnt++; $display("FAIL drop_perr_sticky got=%b want=1", o_perr[2]); end
  endtask

  task automatic test_simultaneous();
    do_write(1, 4'hF, 32'h80, 32'h01020304);
    idle(1, 1);
    tick(1, 4'hF, 4'h1, 32'h80, 32'h000000AB, 1'b0);
    cmp_cnt++; if (o_perr[1] !== 1'b1) begin err_cnt++; $display("FAIL sim_perr got=%b want=1", o_perr[1]); end
    cmp_cnt++; if (o_rvalid[1] !== 1'b0) begin err_cnt++; $display("FAIL sim_rvalid1 got=%b want=0", o_rvalid[1]); end
    idle(1, 1);
    cmp_cnt++; if (o_wdone[1] !== 1'b1) begin err_cnt++; $display("FAIL sim_wdone got=%b want=1", o_wdone[1]); end
    cmp_cnt++; if (o_rvalid[1] !== 1'b0) begin err_cnt++; $display("FAIL sim_rvalid2 got=%b want=0", o_rvalid[1]); end
    idle(1, 1);
    cmp_cnt++; if (o_rvalid[1] !== 1'b0) begin err_cnt++; $display("FAIL sim_rvalid3 got=%b want=0", o_rvalid[1]); end
    do_read(1, 32'h80);
    cmp_cnt++; if (o_rdata[1] !== 32'h010203AB) begin err_cnt++; $display("FAIL sim_rdata got=%h want=010203ab", o_rdata[1]); end
  endtask

  task automatic test_reset_midop();
    do_write(3, 4'hF, 32'h10, 32'h0BADF00D);
    idle(3, 1);
    tick(3, 4'hF, 4'd0, 32'h10, 32'd0, 1'b0);
    tick(3, 4'hF, 4'd0, 32'h14, 32'd0, 1'b0);
    cmp_cnt++; if (o_perr[3] !== 1'b1) begin err_cnt++; $display("FAIL rmid_perr_set got=%b want=1", o_perr[3]); end
    tick(3, 4'd0, 4'd0, 32'd0, 32'd0, 1'b1);
    cmp_cnt++; if (o_busy[3] !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy got=%b want=0", o_busy[3]); end
    cmp_cnt++; if (o_perr[3] !== 1'b0) begin err_cnt++; $display("FAIL rmid_perr_clr got=%b want=0", o_perr[3]); end
    cmp_cnt++; if (o_rvalid[3] !== 1'b0) begin err_cnt++; $display("FAIL rmid_rvalid3 got=%b want=0", o_rvalid[3]); end
    idle(3, 1);
    cmp_cnt++; if (o_rvalid[3] !== 1'b0) begin err_cnt++; $display("FAIL rmid_abandoned got=%b want=0", o_rvalid[3]); end
    tick(3, 4'hF, 4'd0, 32'h10, 32'd0, 1'b0);
    for (int c = 5; c < 8; c++) begin
      cmp_cnt++; if (o_rvalid[3] !== 1'b0) begin err_cnt++; $display("FAIL rmid_early c=%0d got=%b want=0", c, o_rvalid[3]); end
      idle(3, 1);
    end
    cmp_cnt++; if (o_rvalid[3] !== 1'b1) begin err_cnt++; $display("FAIL rmid_rvalid8 got=%b want=1", o_rvalid[3]); end
    cmp_cnt++; if (o_rdata[3] !== 32'h0BADF00D) begin err_cnt++; $display("FAIL rmid_rdata got=%h want=0badf00d", o_rdata[3]); end
  endtask

  task automatic test_alias_stream();
    logic [31:0] exp_w [8];
    tick(0, 4'd0, 4'hF, 32'h0000_1004, 32'h12345678, 1'b0);
    cmp_cnt++; if (o_wdone[0] !== 1'b1) begin err_cnt++; $display("FAIL alias_wdone got=%b want=1", o_wdone[0]); end
    tick(0, 4'hF, 4'd0, 32'h4, 32'd0, 1'b0);
    cmp_cnt++; if (o_rdata[0] !== 32'h12345678 || o_rvalid[0] !== 1'b1)
      begin err_cnt++; $display("FAIL alias_read got=%h/%b want=12345678/1", o_rdata[0], o_rvalid[0]); end
    for (int i = 0; i < 8; i++) begin
      exp_w[i] = $urandom();
      tick(0, 4'd0, 4'hF, 32'(i * 4 + 32), exp_w[i], 1'b0);
      cmp_cnt++; if (o_wdone[0] !== 1'b1) begin err_cnt++; $display("FAIL stream_wdone i=%0d got=%b want=1", i, o_wdone[0]); end
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 4'h3, 4'd0, 32'(i * 4 + 32), 32'd0, 1'b0);
      cmp_cnt++; if (o_rvalid[0] !== 1'b1 || o_rdata[0] !== exp_w[i])
        begin err_cnt++; $display("FAIL stream_read i=%0d got=%h/%b want=%h/1", i, o_rdata[0], o_rvalid[0], exp_w[i]); end
    end
    cmp_cnt++; if (o_perr[0] !== 1'b0) begin err_cnt++; $display("FAIL stream_perr got=%b want=0", o_perr[0]); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ren, wen;
    logic [31:0] addr, hi;
    logic        r;
    int          op;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 16; w++) do_write(k, 4'hF, 32'(w * 4), $urandom());
      for (int n = 0; n < 150; n++) begin
        op  = $urandom_range(0, 9);
        hi  = $urandom();
        addr = (hi & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
        ren = 4'd0; wen = 4'd0;
        r   = ($urandom_range(0, 59) == 0);
        if (op >= 4 && op <= 6) ren = 4'($urandom_range(1, 15));
        if (op == 7 || op == 8) wen = 4'($urandom_range(1, 15));
        if (op == 9) begin ren = 4'hF; wen = 4'($urandom_range(1, 15)); end
        tick(k, ren, wen, addr, $urandom(), r);
        cmp_cnt++; if (o_rvalid[k] !== m_rvalid[k] || o_wdone[k] !== m_wdone[k] || o_busy[k] !== m_busy[k] ||
                       o_perr[k] !== m_perr[k] || o_rdata[k] !== m_rdata[k]) begin
          err_cnt++;
          $display("FAIL rand k=%0d cyc=%0d got rv=%b wd=%b bz=%b pe=%b rd=%h want rv=%b wd=%b bz=%b pe=%b rd=%h",
                   k, cyc, o_rvalid[k], o_wdone[k], o_busy[k], o_perr[k], o_rdata[k],
                   m_rvalid[k], m_wdone[k], m_busy[k], m_perr[k], m_rdata[k]);
        end
      end
      idle(k, 5);
    end
  endtask

  initial begin
    cyc = 0;
    for (int j = 0; j < 4; j++) begin
      t_rst[j] = 1'b1; t_ren[j] = 4'd0; t_wen[j] = 4'd0;
      t_addr[j] = 32'd0; t_wdata[j] = 32'd0;
      m_resp[j] = -1; m_wr[j] = 1'b0; m_idx[j] = 0; m_wen[j] = 4'd0; m_wd[j] = 32'd0;
      m_rvalid[j] = 1'b0; m_wdone[j] = 1'b0; m_busy[j] = 1'b0; m_perr[j] = 1'b0; m_rdata[j] = 32'd0;
    end
    @(negedge clk);
    test_reset();
    test_latency();
    test_byte_lanes();
    test_busy_drop();
    test_simultaneous();
    test_reset_midop();
    test_alias_stream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
